// File: rtl/struct_s.sv
// ============================================================================
//  struct_s_pkg : shared type definitions for the NF bypass datapath
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package struct_s_pkg;
    typedef logic [127:0] metadata_t;
endpackage

`default_nettype wire

// File: rtl/bypass_nf_back_if.sv
// ============================================================================
//  bypass_nf_back_if : packet/metadata bundle for the NF bypass back merge
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface bypass_nf_back_if;
    import struct_s_pkg::*;

    logic [511:0] nf_pkt_data;
    logic         nf_pkt_valid;
    logic         nf_pkt_sop;
    logic         nf_pkt_eop;
    logic [5:0]   nf_pkt_empty;
    logic         nf_pkt_ready;
    metadata_t    nf_meta_data;
    logic         nf_meta_valid;
    logic         nf_meta_ready;

    logic [511:0] byp_pkt_data;
    logic         byp_pkt_valid;
    logic         byp_pkt_sop;
    logic         byp_pkt_eop;
    logic [5:0]   byp_pkt_empty;
    logic         byp_pkt_ready;
    metadata_t    byp_meta_data;
    logic         byp_meta_valid;
    logic         byp_meta_ready;

    logic [511:0] out_pkt_data;
    logic         out_pkt_valid;
    logic         out_pkt_sop;
    logic         out_pkt_eop;
    logic [5:0]   out_pkt_empty;
    logic         out_pkt_almost_full;
    metadata_t    out_meta_data;
    logic         out_meta_valid;
    logic         out_meta_almost_full;

    logic [31:0]  nf_pkt_cnt;
    logic [31:0]  byp_pkt_cnt;

    // Merge block side
    modport slave (
        input  nf_pkt_data, nf_pkt_valid, nf_pkt_sop, nf_pkt_eop, nf_pkt_empty,
        output nf_pkt_ready,
        input  nf_meta_data, nf_meta_valid,
        output nf_meta_ready,
        input  byp_pkt_data, byp_pkt_valid, byp_pkt_sop, byp_pkt_eop, byp_pkt_empty,
        output byp_pkt_ready,
        input  byp_meta_data, byp_meta_valid,
        output byp_meta_ready,
        output out_pkt_data, out_pkt_valid, out_pkt_sop, out_pkt_eop, out_pkt_empty,
        input  out_pkt_almost_full,
        output out_meta_data, out_meta_valid,
        input  out_meta_almost_full,
        output nf_pkt_cnt, byp_pkt_cnt
    );

    // Surrounding FIFOs / environment side
    modport master (
        output nf_pkt_data, nf_pkt_valid, nf_pkt_sop, nf_pkt_eop, nf_pkt_empty,
        input  nf_pkt_ready,
        output nf_meta_data, nf_meta_valid,
        input  nf_meta_ready,
        output byp_pkt_data, byp_pkt_valid, byp_pkt_sop, byp_pkt_eop, byp_pkt_empty,
        input  byp_pkt_ready,
        output byp_meta_data, byp_meta_valid,
        input  byp_meta_ready,
        input  out_pkt_data, out_pkt_valid, out_pkt_sop, out_pkt_eop, out_pkt_empty,
        output out_pkt_almost_full,
        input  out_meta_data, out_meta_valid,
        output out_meta_almost_full,
        input  nf_pkt_cnt, byp_pkt_cnt
    );
endinterface

`default_nettype wire

// File: rtl/bypass_nf_back.sv
// ============================================================================
//  bypass_nf_back : packet-atomic merge of NF output and bypass path streams.
//  Optional macro BYPASS_MERGE_RR_EN selects round-robin instead of NF priority.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module bypass_nf_back (
    input  logic              clk,
    input  logic              rst_n,
    bypass_nf_back_if.slave   bus
);
    import struct_s_pkg::*;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] FWD_NF  = 2'd1;
    localparam logic [1:0] FWD_BYP = 2'd2;

    localparam logic SRC_NF  = 1'b0;
    localparam logic SRC_BYP = 1'b1;

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic         r_pkt_done;
    logic         r_meta_done;
    logic         r_last_served;
    logic [31:0]  r_nf_pkt_cnt;
    logic [31:0]  r_byp_pkt_cnt;

    logic         r_out_pkt_valid;
    logic [511:0] r_out_pkt_data;
    logic         r_out_pkt_sop;
    logic         r_out_pkt_eop;
    logic [5:0]   r_out_pkt_empty;
    logic         r_out_meta_valid;
    metadata_t    r_out_meta_data;

    logic         w_fwd_nf;
    logic         w_fwd_byp;
    logic         w_nf_pkt_rdy;
    logic         w_nf_meta_rdy;
    logic         w_byp_pkt_rdy;
    logic         w_byp_meta_rdy;
    logic         w_pkt_acc;
    logic         w_meta_acc;
    logic         w_finish;
    logic         w_out_open;
    logic         w_nf_cand;
    logic         w_byp_cand;
    logic         w_pick_nf;
    logic         w_pick_byp;

    logic [511:0] w_sel_pkt_data;
    logic         w_sel_pkt_sop;
    logic         w_sel_pkt_eop;
    logic [5:0]   w_sel_pkt_empty;
    metadata_t    w_sel_meta_data;

    assign w_fwd_nf  = (r_state == FWD_NF);
    assign w_fwd_byp = (r_state == FWD_BYP);

    // Readies depend only on state, done flags and downstream almost_full
    assign w_nf_pkt_rdy   = w_fwd_nf  & ~r_pkt_done  & ~bus.out_pkt_almost_full;
    assign w_nf_meta_rdy  = w_fwd_nf  & ~r_meta_done & ~bus.out_meta_almost_full;
    assign w_byp_pkt_rdy  = w_fwd_byp & ~r_pkt_done  & ~bus.out_pkt_almost_full;
    assign w_byp_meta_rdy = w_fwd_byp & ~r_meta_done & ~bus.out_meta_almost_full;

    assign w_pkt_acc  = (w_nf_pkt_rdy  & bus.nf_pkt_valid)  | (w_byp_pkt_rdy  & bus.byp_pkt_valid);
    assign w_meta_acc = (w_nf_meta_rdy & bus.nf_meta_valid) | (w_byp_meta_rdy & bus.byp_meta_valid);

    assign w_finish = (w_fwd_nf | w_fwd_byp) & r_pkt_done & r_meta_done;

    assign w_sel_pkt_data  = w_fwd_byp ? bus.byp_pkt_data  : bus.nf_pkt_data;
    assign w_sel_pkt_sop   = w_fwd_byp ? bus.byp_pkt_sop   : bus.nf_pkt_sop;
    assign w_sel_pkt_eop   = w_fwd_byp ? bus.byp_pkt_eop   : bus.nf_pkt_eop;
    assign w_sel_pkt_empty = w_fwd_byp ? bus.byp_pkt_empty : bus.nf_pkt_empty;
    assign w_sel_meta_data = w_fwd_byp ? bus.byp_meta_data : bus.nf_meta_data;

    // A new packet is only started when downstream has room on both channels
    assign w_out_open = ~bus.out_pkt_almost_full & ~bus.out_meta_almost_full;
    assign w_nf_cand  = bus.nf_pkt_valid  & w_out_open;
    assign w_byp_cand = bus.byp_pkt_valid & w_out_open;

`ifdef BYPASS_MERGE_RR_EN
    assign w_pick_byp = w_byp_cand & (~w_nf_cand | (r_last_served == SRC_NF));
`else
    assign w_pick_byp = w_byp_cand & ~w_nf_cand;
`endif
    assign w_pick_nf  = w_nf_cand & ~w_pick_byp;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_pick_nf) begin
                    w_state_nxt = FWD_NF;
                end else if (w_pick_byp) begin
                    w_state_nxt = FWD_BYP;
                end
            end
            FWD_NF, FWD_BYP: begin
                if (w_finish) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_pkt_done       <= 1'b0;
            r_meta_done      <= 1'b0;
            r_last_served    <= SRC_BYP;
            r_nf_pkt_cnt     <= 32'd0;
            r_byp_pkt_cnt    <= 32'd0;
            r_out_pkt_valid  <= 1'b0;
            r_out_meta_valid <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_out_pkt_valid  <= w_pkt_acc;
            r_out_meta_valid <= w_meta_acc;

            if ((r_state == IDLE) || w_finish) begin
                r_pkt_done  <= 1'b0;
                r_meta_done <= 1'b0;
            end else begin
                if (w_pkt_acc && w_sel_pkt_eop) begin
                    r_pkt_done <= 1'b1;
                end
                if (w_meta_acc) begin
                    r_meta_done <= 1'b1;
                end
            end

            if (w_finish && w_fwd_nf) begin
                r_nf_pkt_cnt  <= r_nf_pkt_cnt + 32'd1;
                r_last_served <= SRC_NF;
            end
            if (w_finish && w_fwd_byp) begin
                r_byp_pkt_cnt <= r_byp_pkt_cnt + 32'd1;
                r_last_served <= SRC_BYP;
            end
        end
    end

    // Payload registers carry no reset; the valid bits qualify them
    always_ff @(posedge clk) begin
        if (w_pkt_acc) begin
            r_out_pkt_data  <= w_sel_pkt_data;
            r_out_pkt_sop   <= w_sel_pkt_sop;
            r_out_pkt_eop   <= w_sel_pkt_eop;
            r_out_pkt_empty <= w_sel_pkt_empty;
        end
        if (w_meta_acc) begin
            r_out_meta_data <= w_sel_meta_data;
        end
    end

    assign bus.nf_pkt_ready   = w_nf_pkt_rdy;
    assign bus.nf_meta_ready  = w_nf_meta_rdy;
    assign bus.byp_pkt_ready  = w_byp_pkt_rdy;
    assign bus.byp_meta_ready = w_byp_meta_rdy;

    assign bus.out_pkt_valid  = r_out_pkt_valid;
    assign bus.out_pkt_data   = r_out_pkt_data;
    assign bus.out_pkt_sop    = r_out_pkt_sop;
    assign bus.out_pkt_eop    = r_out_pkt_eop;
    assign bus.out_pkt_empty  = r_out_pkt_empty;
    assign bus.out_meta_valid = r_out_meta_valid;
    assign bus.out_meta_data  = r_out_meta_data;

    assign bus.nf_pkt_cnt     = r_nf_pkt_cnt;
    assign bus.byp_pkt_cnt    = r_byp_pkt_cnt;

endmodule

`default_nettype wire
